// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths and arithmetic helpers for the convolution layer
package cnn_pkg;

  // Ceiling log2 for elaboration-time width derivation
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Accumulator width: full product width plus growth for n_terms additions
  function automatic int acc_bw(input int i_f_bw, input int w_bw, input int n_terms);
    return i_f_bw + w_bw + 1 + clog2(n_terms);
  endfunction

  // Optional ReLU followed by saturation into a signed ow-bit range
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input logic relu,
                                                  input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    r  = v;
    if (relu && v[63]) r = '0;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cnn_conv_layer_if.sv
// rtl/cnn_conv_layer_if.sv - pixel input and result output streams of the layer
interface cnn_conv_layer_if #(
  parameter int I_F_BW = 8,
  parameter int CI     = 1,
  parameter int CO     = 3,
  parameter int O_F_BW = 20
) ();
  logic                   i_in_valid;
  logic [CI*I_F_BW-1:0]   i_in_fmap;
  logic                   o_ot_valid;
  logic                   o_ot_last;
  logic [CO*O_F_BW-1:0]   o_ot_fmap;

  modport master (output i_in_valid, output i_in_fmap,
                  input  o_ot_valid, input  o_ot_last, input o_ot_fmap);
  modport slave  (input  i_in_valid, input  i_in_fmap,
                  output o_ot_valid, output o_ot_last, output o_ot_fmap);
endinterface

// File: rtl/cnn_window_buf.sv
// rtl/cnn_window_buf.sv - per-channel line buffers and KYxKX sliding window
module cnn_window_buf #(
  parameter int I_F_BW = 8,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int IX     = 28,
  parameter int CW     = 5
) (
  input  logic                      clk,
  input  logic                      i_shift,
  input  logic [CW-1:0]             i_col,
  input  logic [I_F_BW-1:0]         i_pixel,
  output logic [KY*KX*I_F_BW-1:0]   o_window
);

  // line_q[j][col] holds the pixel j+1 rows above the current one at that column
  logic [I_F_BW-1:0] line_q [KY-1][IX];
  logic [I_F_BW-1:0] line_d [KY-1][IX];
  // win_q[ky][kx] holds the columns left of the current one (kx = KX-2 is nearest)
  logic [I_F_BW-1:0] win_q  [KY][KX-1];
  logic [I_F_BW-1:0] win_d  [KY][KX-1];
  logic [I_F_BW-1:0] col_vec [KY];

  // Current column of the window: line buffer reads above, live pixel at the bottom
  always_comb begin
    col_vec[KY-1] = i_pixel;
    for (int j = 0; j < KY - 1; j++) begin
      col_vec[KY-2-j] = line_q[j][i_col];
    end
  end

  // On an accepted pixel cascade rows down the line buffers and shift the window left
  always_comb begin
    line_d = line_q;
    win_d  = win_q;
    if (i_shift) begin
      line_d[0][i_col] = i_pixel;
      for (int j = 1; j < KY - 1; j++) begin
        line_d[j][i_col] = line_q[j-1][i_col];
      end
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX - 2; kx++) begin
          win_d[ky][kx] = win_q[ky][kx+1];
        end
        win_d[ky][KX-2] = col_vec[ky];
      end
    end
  end

  // Flatten the window, element (ky,kx) at (ky*KX+kx)*I_F_BW
  always_comb begin
    o_window = '0;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX - 1; kx++) begin
        o_window[(ky*KX+kx)*I_F_BW +: I_F_BW] = win_q[ky][kx];
      end
      o_window[(ky*KX+KX-1)*I_F_BW +: I_F_BW] = col_vec[ky];
    end
  end

  // Data storage only; nothing downstream looks at it before a valid window
  always_ff @(posedge clk) begin
    line_q <= line_d;
    win_q  <= win_d;
  end

endmodule

// File: rtl/cnn_conv_layer.sv
// rtl/cnn_conv_layer.sv - streaming 2D convolution layer, 3-stage multiply/sum/activate pipeline
module cnn_conv_layer
  import cnn_pkg::*;
#(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 8,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int IX     = 28,
  parameter int IY     = 28,
  parameter int CI     = 1,
  parameter int CO     = 3,
  parameter int O_F_BW = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_clear,
  input  logic                         i_relu_en,
  input  logic [CO*CI*KY*KX*W_BW-1:0]  i_cnn_weight,
  input  logic [CO*B_BW-1:0]           i_cnn_bias,
  cnn_conv_layer_if.slave              bus
);

  localparam int ACC_BW = acc_bw(I_F_BW, W_BW, CI*KX*KY);
  localparam int NTAP   = CI*KY*KX;
  localparam int NPROD  = CO*NTAP;
  localparam int PW     = I_F_BW + W_BW + 1;
  localparam int CW     = (clog2(IX) > 0) ? clog2(IX) : 1;
  localparam int RW     = (clog2(IY) > 0) ? clog2(IY) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IX - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IY - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KY - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept, win_valid, win_last;
  logic [KY*KX*I_F_BW-1:0] win_flat [CI];

  logic signed [PW-1:0]     prod_q [NPROD];
  logic signed [PW-1:0]     prod_d [NPROD];
  logic signed [ACC_BW-1:0] sum_q  [CO];
  logic signed [ACC_BW-1:0] sum_d  [CO];
  logic [CO*O_F_BW-1:0]     fmap_q, fmap_d;
  logic v1_q, v1_d, l1_q, l1_d;
  logic v2_q, v2_d, l2_q, l2_d;
  logic ov_q, ov_d, ol_q, ol_d;

  assign accept = bus.i_in_valid && !i_clear;

  for (genvar ci = 0; ci < CI; ci++) begin : g_win
    cnn_window_buf #(
      .I_F_BW(I_F_BW), .KX(KX), .KY(KY), .IX(IX), .CW(CW)
    ) u_buf (
      .clk      (clk),
      .i_shift  (accept),
      .i_col    (col_q),
      .i_pixel  (bus.i_in_fmap[ci*I_F_BW +: I_F_BW]),
      .o_window (win_flat[ci])
    );
  end

  // Raster position counters; a window exists once KY-1 rows and KX-1 columns are behind us
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_valid = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
    win_last  = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
    if (i_clear) begin
      col_d = '0;
      row_d = '0;
    end else if (bus.i_in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Stage 1: every tap times its weight, pixel treated as unsigned
  always_comb begin
    logic [I_F_BW-1:0] pix;
    logic [W_BW-1:0]   w;
    int                idx;
    pix    = '0;
    w      = '0;
    idx    = 0;
    prod_d = prod_q;
    if (win_valid) begin
      for (int co = 0; co < CO; co++) begin
        for (int ci = 0; ci < CI; ci++) begin
          for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
              idx         = ((co*CI + ci)*KY + ky)*KX + kx;
              pix         = win_flat[ci][(ky*KX + kx)*I_F_BW +: I_F_BW];
              w           = i_cnn_weight[idx*W_BW +: W_BW];
              prod_d[idx] = $signed({1'b0, pix}) * $signed(w);
            end
          end
        end
      end
    end
  end

  // Stage 2: per output channel sum of its taps at full accumulator width
  always_comb begin
    sum_d = sum_q;
    if (v1_q) begin
      for (int co = 0; co < CO; co++) begin
        sum_d[co] = '0;
        for (int j = 0; j < NTAP; j++) begin
          sum_d[co] = sum_d[co] + ACC_BW'(prod_q[co*NTAP + j]);
        end
      end
    end
  end

  // Stage 3: bias, activation and saturation; result holds between outputs
  always_comb begin
    logic signed [63:0] biased;
    biased = '0;
    fmap_d = fmap_q;
    if (v2_q) begin
      for (int co = 0; co < CO; co++) begin
        biased = 64'(sum_q[co]) + 64'($signed(i_cnn_bias[co*B_BW +: B_BW]));
        fmap_d[co*O_F_BW +: O_F_BW] = O_F_BW'(sat_relu(biased, i_relu_en, O_F_BW));
      end
    end
  end

  // Stage valid/last chain; a clear drops everything in flight
  always_comb begin
    v1_d = win_valid;
    l1_d = win_last;
    v2_d = v1_q && !i_clear;
    l2_d = l1_q && !i_clear;
    ov_d = v2_q && !i_clear;
    ol_d = l2_q && !i_clear;
  end

  // Control state and the visible result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      v1_q   <= 1'b0;
      l1_q   <= 1'b0;
      v2_q   <= 1'b0;
      l2_q   <= 1'b0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      fmap_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      v1_q   <= v1_d;
      l1_q   <= l1_d;
      v2_q   <= v2_d;
      l2_q   <= l2_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      fmap_q <= fmap_d;
    end
  end

  // Pipeline data; only consumed behind a valid bit
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  assign bus.o_ot_valid = ov_q;
  assign bus.o_ot_last  = ol_q;
  assign bus.o_ot_fmap  = fmap_q;

endmodule

// File: tb/tb_cnn_conv_layer.sv
// tb/tb_cnn_conv_layer.sv - self-checking bench, two layer configurations run in lockstep
module tb_cnn_conv_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         clear;
  logic         relu_a, relu_b;
  logic [71:0]  w_a;
  logic [7:0]   b_a;
  logic [287:0] w_b;
  logic [15:0]  b_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_conv_layer_if #(.I_F_BW(8), .CI(1), .CO(1), .O_F_BW(20)) a_if ();
  cnn_conv_layer_if #(.I_F_BW(8), .CI(2), .CO(2), .O_F_BW(8))  b_if ();

  cnn_conv_layer #(.I_F_BW(8), .W_BW(8), .B_BW(8), .KX(3), .KY(3), .IX(4), .IY(4),
                   .CI(1), .CO(1), .O_F_BW(20)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_relu_en(relu_a),
    .i_cnn_weight(w_a), .i_cnn_bias(b_a), .bus(a_if));

  cnn_conv_layer #(.I_F_BW(8), .W_BW(8), .B_BW(8), .KX(3), .KY(3), .IX(4), .IY(4),
                   .CI(2), .CO(2), .O_F_BW(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_relu_en(relu_b),
    .i_cnn_weight(w_b), .i_cnn_bias(b_b), .bus(b_if));

  int checks = 0;
  int errors = 0;

  // Frame images and coefficients: [inst][co][ci][ky][kx], inst 0 = a, 1 = b
  int img [2][2][4][4];
  int wt  [2][2][2][3][3];
  int bs  [2][2];

  typedef struct {int due; bit last; int a0; int b0; int b1;} exp_t;
  exp_t q[$];

  int n_out, n_last, last_idx, first_cyc, t22;
  int last_a, last_b0, last_b1, prev_a, prev_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct convolution of the stored frame for the window ending at (r,c)
  function automatic int model(input int inst, input int co, input int r, input int c);
    int     nci;
    int     ow;
    logic   relu;
    longint s, hi, lo;
    nci  = (inst == 0) ? 1 : 2;
    ow   = (inst == 0) ? 20 : 8;
    relu = (inst == 0) ? relu_a : relu_b;
    s    = bs[inst][co];
    for (int ci = 0; ci < nci; ci++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += longint'(img[inst][ci][r-2+ky][c-2+kx] * wt[inst][co][ci][ky][kx]);
    if (relu && s < 0) s = 0;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -(longint'(1) << (ow - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return int'(s);
  endfunction

  task automatic pack();
    for (int co = 0; co < 2; co++)
      for (int ci = 0; ci < 2; ci++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            if (co == 0 && ci == 0) w_a[(ky*3 + kx)*8 +: 8] = 8'(wt[0][0][0][ky][kx]);
            w_b[(((co*2 + ci)*3 + ky)*3 + kx)*8 +: 8] = 8'(wt[1][co][ci][ky][kx]);
          end
    b_a = 8'(bs[0][0]);
    b_b = {8'(bs[1][1]), 8'(bs[1][0])};
  endtask

  task automatic set_w(input int inst, input int co, input int v, input int b);
    for (int ci = 0; ci < 2; ci++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) wt[inst][co][ci][ky][kx] = v;
    bs[inst][co] = b;
  endtask

  task automatic set_img(input int inst, input int ci, input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[inst][ci][r][c] = v;
  endtask

  task automatic randomize_all();
    for (int i = 0; i < 2; i++) begin
      for (int co = 0; co < 2; co++) begin
        bs[i][co] = int'($urandom_range(0, 255)) - 128;
        for (int ci = 0; ci < 2; ci++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              wt[i][co][ci][ky][kx] = int'($urandom_range(0, 255)) - 128;
      end
      for (int ci = 0; ci < 2; ci++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) img[i][ci][r][c] = int'($urandom_range(0, 255));
    end
    pack();
  endtask

  task automatic drive_pix(input int r, input int c);
    exp_t e;
    @(posedge clk); #1;
    clear           = 1'b0;
    a_if.i_in_valid = 1'b1;
    b_if.i_in_valid = 1'b1;
    a_if.i_in_fmap  = 8'(img[0][0][r][c]);
    b_if.i_in_fmap  = {8'(img[1][1][r][c]), 8'(img[1][0][r][c])};
    if (r == 2 && c == 2) t22 = cyc;
    if (r >= 2 && c >= 2) begin
      e.due  = cyc + 3;
      e.last = (r == 3 && c == 3);
      e.a0   = model(0, 0, r, c);
      e.b0   = model(1, 0, r, c);
      e.b1   = model(1, 1, r, c);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear           = 1'b0;
      a_if.i_in_valid = 1'b0;
      b_if.i_in_valid = 1'b0;
    end
  endtask

  task automatic frame(input bit gaps);
    n_out  = 0;
    n_last = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (gaps) idle(int'($urandom_range(0, 3)));
        drive_pix(r, c);
      end
    idle(6);
  endtask

  task automatic partial(input int n);
    n_out = 0;
    for (int i = 0; i < n; i++) drive_pix(i / 4, i % 4);
  endtask

  // Clear (optionally with a simultaneous pixel); anything not yet visible never appears
  task automatic do_clear(input bit with_valid);
    @(posedge clk); #1;
    clear           = 1'b1;
    a_if.i_in_valid = with_valid;
    b_if.i_in_valid = with_valid;
    a_if.i_in_fmap  = 8'd77;
    b_if.i_in_fmap  = 16'h4D4D;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    idle(1);
  endtask

  // Compare process: every output against the model queue, holds while idle
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (a_if.o_ot_valid || b_if.o_ot_valid || (q.size() > 0 && q[0].due <= cyc)) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid_a", int'(a_if.o_ot_valid), 1);
          chk("valid_b", int'(b_if.o_ot_valid), 1);
          chk("out_cycle", cyc, e.due);
          chk("fmap_a", int'($signed(a_if.o_ot_fmap)), e.a0);
          chk("fmap_b0", int'($signed(b_if.o_ot_fmap[7:0])), e.b0);
          chk("fmap_b1", int'($signed(b_if.o_ot_fmap[15:8])), e.b1);
          chk("last_a", int'(a_if.o_ot_last), int'(e.last));
          chk("last_b", int'(b_if.o_ot_last), int'(e.last));
          if (n_out == 0) first_cyc = cyc;
          n_out++;
          if (a_if.o_ot_last) begin
            n_last++;
            last_idx = n_out;
          end
          last_a  = int'($signed(a_if.o_ot_fmap));
          last_b0 = int'($signed(b_if.o_ot_fmap[7:0]));
          last_b1 = int'($signed(b_if.o_ot_fmap[15:8]));
        end
      end else begin
        chk("hold_a", int'(a_if.o_ot_fmap), prev_a);
        chk("hold_b", int'(b_if.o_ot_fmap), prev_b);
        chk("idle_last", int'(a_if.o_ot_last | b_if.o_ot_last), 0);
      end
    end
    prev_a = int'(a_if.o_ot_fmap);
    prev_b = int'(b_if.o_ot_fmap);
  end

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    relu_a  = 1'b0;
    relu_b  = 1'b0;
    a_if.i_in_valid = 1'b0;
    b_if.i_in_valid = 1'b0;
    a_if.i_in_fmap  = '0;
    b_if.i_in_fmap  = '0;
    n_out = 0; n_last = 0; last_idx = 0; first_cyc = 0; t22 = 0;
    last_a = 0; last_b0 = 0; last_b1 = 0; prev_a = 0; prev_b = 0;
    for (int i = 0; i < 2; i++) begin
      set_w(i, 0, 0, 0);
      set_w(i, 1, 0, 0);
      set_img(i, 0, 0);
      set_img(i, 1, 0);
    end
    pack();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", int'(a_if.o_ot_valid), 0);
    chk("rst_last_a", int'(a_if.o_ot_last), 0);
    chk("rst_fmap_a", int'(a_if.o_ot_fmap), 0);
    chk("rst_fmap_b", int'(b_if.o_ot_fmap), 0);
    reset_n = 1'b1;
    idle(2);

    // Ones everywhere; two-channel instance checks per-channel weights and bias
    set_w(0, 0, 1, 0);
    set_img(0, 0, 1);
    set_w(1, 0, 1, 0);
    set_w(1, 1, 0, -5);
    set_img(1, 0, 1);
    set_img(1, 1, 2);
    pack();
    frame(0);
    chk("t1_count", n_out, 4);
    chk("t1_last_count", n_last, 1);
    chk("t1_last_idx", last_idx, 4);
    chk("t1_a", last_a, 9);
    chk("t1_b0", last_b0, 27);
    chk("t1_b1", last_b1, -5);
    chk("t1_latency", first_cyc - t22, 3);

    // Negative weights, linear then ReLU
    set_w(0, 0, -1, 2);
    pack();
    frame(0);
    chk("t2_linear", last_a, -7);
    relu_a = 1'b1;
    frame(0);
    chk("t2_relu", last_a, 0);
    relu_a = 1'b0;

    // Saturation of the 8-bit result at both ends
    set_w(1, 0, 127, 127);
    set_w(1, 1, 127, 127);
    set_img(1, 0, 255);
    set_img(1, 1, 255);
    pack();
    frame(0);
    chk("t3_sat_hi_b0", last_b0, 127);
    chk("t3_sat_hi_b1", last_b1, 127);
    set_w(1, 0, -128, 127);
    set_w(1, 1, -128, 127);
    pack();
    frame(0);
    chk("t3_sat_lo_b0", last_b0, -128);
    chk("t3_sat_lo_b1", last_b1, -128);

    // Random frames, gapless then with idle cycles between pixels
    for (int k = 0; k < 3; k++) begin
      randomize_all();
      relu_b = k[0];
      frame(0);
      chk("rand_count", n_out, 4);
      frame(1);
      chk("rand_gap_count", n_out, 4);
    end
    relu_b = 1'b0;

    // Abort paths, back on the all-ones configuration
    set_w(0, 0, 1, 0);
    set_img(0, 0, 1);
    set_w(1, 0, 1, 0);
    set_w(1, 1, 0, -5);
    set_img(1, 0, 1);
    set_img(1, 1, 2);
    pack();
    partial(7);
    do_clear(1);
    idle(2);
    frame(0);
    chk("clr_count", n_out, 4);
    chk("clr_a", last_a, 9);
    partial(11);
    do_clear(0);
    idle(4);
    chk("clr_inflight_killed", n_out, 0);
    frame(0);
    chk("clr2_count", n_out, 4);
    chk("clr2_last_count", n_last, 1);

    partial(7);
    @(posedge clk); #1;
    reset_n = 1'b0;
    a_if.i_in_valid = 1'b0;
    b_if.i_in_valid = 1'b0;
    q.delete();
    #1;
    chk("async_rst_fmap_a", int'(a_if.o_ot_fmap), 0);
    chk("async_rst_fmap_b", int'(b_if.o_ot_fmap), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    frame(0);
    chk("rst_frame_count", n_out, 4);
    chk("rst_frame_a", last_a, 9);
    chk("rst_frame_b0", last_b0, 27);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_conv_layer.md
CNN_CONV_LAYER -- requirements
Module: cnn_conv_layer

Interface
REQ-001 SHALL have parameters: I_F_BW 8 (unsigned pixel width), W_BW 8 (signed weight width), B_BW 8 (signed bias width), KX 5 / KY 5 (kernel size), IX 28 / IY 28 (frame size), CI 1 (input channels), CO 3 (output channels), O_F_BW 20 (signed output width).
REQ-002 SHALL derive localparam ACC_BW = I_F_BW+W_BW+1+clog2(CI*KX*KY).
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_clear  in  1  synchronous abort; clears counters and pipeline valids.
REQ-006 i_relu_en  in  1  1 = ReLU, 0 = linear; sampled per output in stage 3.
REQ-007 i_cnn_weight  in  CO*CI*KY*KX*W_BW  weight (co,ci,ky,kx) at bit offset (((co*CI+ci)*KY+ky)*KX+kx)*W_BW.
REQ-008 i_cnn_bias  in  CO*B_BW  bias co at offset co*B_BW.
REQ-009 i_in_valid  in  1  pixel strobe, raster order, no backpressure.
REQ-010 i_in_fmap  in  CI*I_F_BW  channel ci pixel at offset ci*I_F_BW.
REQ-011 o_ot_valid  out  1  output strobe.
REQ-012 o_ot_last  out  1  high with last output of a frame.
REQ-013 o_ot_fmap  out  CO*O_F_BW  signed result, channel co at offset co*O_F_BW.

Function
REQ-014 SHALL keep column counter 0..IX-1 and row counter 0..IY-1, advancing only on i_in_valid; column wraps to 0 and increments row; row IY-1/column IX-1 wraps both to 0 (next frame).
REQ-015 SHALL form a KYxKX window per channel; element (ky,kx): ky=0 oldest row, kx=0 leftmost column; current pixel is (KY-1,KX-1).
REQ-016 Window SHALL be valid only on an accepted pixel with row>=KY-1 and column>=KX-1; no windows spanning a line wrap; (IX-KX+1)*(IY-KY+1) outputs per frame.
REQ-017 Stage 1 SHALL register all CO*CI*KY*KX products: zero-extended pixel times signed weight.
REQ-018 Stage 2 SHALL register per-co sum over ci,ky,kx at ACC_BW signed, no overflow.
REQ-019 Stage 3 SHALL add sign-extended bias, apply ReLU (negative -> 0) when i_relu_en, saturate to [-2^(O_F_BW-1), 2^(O_F_BW-1)-1], and register o_ot_fmap.
REQ-020 Latency SHALL be exactly 3 cycles from the valid-window pixel to o_ot_valid; one output per valid window, throughput 1/cycle, gaps in i_in_valid allowed.
REQ-021 o_ot_last SHALL assert with the output of window row IY-1, column IX-1 only.
REQ-022 o_ot_fmap SHALL hold its value while o_ot_valid is low.
REQ-023 i_clear SHALL win over a simultaneous i_in_valid: pixel dropped, counters to 0, stage valids to 0, o_ot_valid low next cycle; line-buffer contents need not clear.
REQ-024 Weights and bias SHALL be static during a frame; changes mid-frame give undefined results.

Reset
REQ-025 On reset_n low: counters 0, all stage valids 0, o_ot_valid 0, o_ot_last 0, o_ot_fmap 0, immediately and asynchronously.
REQ-026 Line-buffer and product data regs need no reset; output must not depend on them before the first valid window.

Structure
REQ-027 Package cnn_pkg SHALL hold clog2 function, ACC_BW derivation and saturation/ReLU helper function.
REQ-028 Single sub-module cnn_window_buf (one per ci via generate): KY-1 line FIFOs of depth IX plus KYxKX window regs; counters and valid logic SHALL be shared, in top level.

Verification
REQ-029 KX=KY=3, IX=IY=4, CI=CO=1, weights 1, bias 0, pixels 1 -> 4 outputs of 9, o_ot_last on 4th, first output 3 cycles after pixel (2,2).
REQ-030 Same, weights -1, bias 2: i_relu_en=0 -> -7; i_relu_en=1 -> 0.
REQ-031 O_F_BW=8, weights 127, bias 127, pixels 255 -> outputs 127 (saturated); weights -128 -> -128.
REQ-032 CI=2, CO=2: ch0 pixels 1, ch1 pixels 2; co0 weights 1, co1 weights 0/bias -5 -> co0 27, co1 -5 (linear).
REQ-033 Random idle cycles between pixels -> outputs identical to gapless run, each 3 cycles after its pixel.
REQ-034 i_clear (and separately reset_n) mid-frame after 7 pixels, then full frame -> no outputs from aborted frame, 4 correct outputs of 9 afterwards.
